// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor stand-in: FSM state encoding,
// LFSR feedback taps and generator mode selectors.
package sensor_pkg;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_READY} sensor_state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int GEN_CNT  = 0;
  localparam int GEN_LFSR = 1;

endpackage

// File: rtl/sensor_gen.sv
// Sample value generator: holds the pending sample and steps to the next
// value (counter or Galois LFSR) only when the current one is consumed.
module sensor_gen
  import sensor_pkg::*;
#(
  parameter int          GEN_MODE = GEN_CNT,
  parameter logic [31:0] SEED     = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [31:0] value
);

  if (GEN_MODE == GEN_LFSR && SEED == 32'h0) begin : g_seed_check
    $error("sensor_gen: SEED must be nonzero in LFSR mode");
  end

  logic [31:0] gen;
  logic [31:0] gen_next;

  always_comb begin
    gen_next = gen + 32'd1;
    if (GEN_MODE == GEN_LFSR) begin
      gen_next = (gen >> 1) ^ (gen[0] ? LFSR_TAPS : 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gen <= SEED;
    end else if (adv) begin
      gen <= gen_next;
    end
  end

  assign value = gen;

endmodule

// File: rtl/sensor_src.sv
// Transmit end of the sensor link: converts for CONV_LAT cycles while
// sensor_en is high, then presents one sample and holds it until accepted.
module sensor_src
  import sensor_pkg::*;
#(
  parameter int          CONV_LAT = 4,
  parameter int          GEN_MODE = GEN_CNT,
  parameter logic [31:0] SEED     = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sensor_en,
  output logic        sensor_ready,
  output logic [31:0] sensor_out,
  output logic [15:0] sample_cnt
);

  if (CONV_LAT < 1 || CONV_LAT > 255) begin : g_lat_check
    $error("sensor_src: CONV_LAT must be in 1..255");
  end

  localparam logic [7:0] LAT_INIT = 8'(CONV_LAT - 1);

  // Handshake: sensor_ready is the valid flag, sensor_en acts as ready.
  // A sample transfers only on a posedge where both are high; while
  // sensor_ready is high, sensor_out is stable regardless of sensor_en.
  sensor_state_e state;
  logic [7:0]    lat_cnt;
  logic [31:0]   gen_val;
  logic          accept;

  assign accept = sensor_en && sensor_ready;

  sensor_gen #(
    .GEN_MODE (GEN_MODE),
    .SEED     (SEED)
  ) u_gen (
    .clk   (clk),
    .rst   (rst),
    .adv   (accept),
    .value (gen_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sensor_ready <= 1'b0;
      sensor_out   <= 32'h0;
      sample_cnt   <= 16'h0;
      lat_cnt      <= 8'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sensor_en) begin
            state   <= S_CONV;
            lat_cnt <= LAT_INIT;
          end
        end
        S_CONV: begin
          // Abort leaves the generator untouched, so the retry yields the same value.
          if (!sensor_en) begin
            state <= S_IDLE;
          end else if (lat_cnt == 8'h0) begin
            state        <= S_READY;
            sensor_ready <= 1'b1;
            sensor_out   <= gen_val;
          end else begin
            lat_cnt <= lat_cnt - 8'h1;
          end
        end
        S_READY: begin
          if (sensor_en) begin
            state        <= S_CONV;
            sensor_ready <= 1'b0;
            lat_cnt      <= LAT_INIT;
            sample_cnt   <= sample_cnt + 16'h1;
          end
        end
        default: begin
          state        <= S_IDLE;
          sensor_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_src.sv
// Bench for sensor_src: three instances (counter, LFSR, wrapping counter)
// checked every cycle against a consecutive-enable reference model.
module tb_sensor_src;

  localparam int          CL_A = 4;
  localparam logic [31:0] SEED_A = 32'h0000_0100;
  localparam int          CL_B = 3;
  localparam logic [31:0] SEED_B = 32'h0000_0001;
  localparam int          CL_C = 1;
  localparam logic [31:0] SEED_C = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  en  = 3'b111;
  logic        rdy  [3];
  logic [31:0] dout [3];
  logic [15:0] cnt  [3];

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic        m_ready [3];
  logic [31:0] m_out   [3];
  logic [15:0] m_cnt   [3];
  logic [31:0] m_gen   [3];
  int          m_run   [3];
  logic        prev_rdy [3];

  logic [31:0] exp_q_b[$];
  logic [31:0] exp_q_c[$];

  always #5 clk = ~clk;

  sensor_src #(.CONV_LAT(CL_A), .GEN_MODE(0), .SEED(SEED_A)) dut_a (
    .clk(clk), .rst(rst), .sensor_en(en[0]),
    .sensor_ready(rdy[0]), .sensor_out(dout[0]), .sample_cnt(cnt[0]));

  sensor_src #(.CONV_LAT(CL_B), .GEN_MODE(1), .SEED(SEED_B)) dut_b (
    .clk(clk), .rst(rst), .sensor_en(en[1]),
    .sensor_ready(rdy[1]), .sensor_out(dout[1]), .sample_cnt(cnt[1]));

  sensor_src #(.CONV_LAT(CL_C), .GEN_MODE(0), .SEED(SEED_C)) dut_c (
    .clk(clk), .rst(rst), .sensor_en(en[2]),
    .sensor_ready(rdy[2]), .sensor_out(dout[2]), .sample_cnt(cnt[2]));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int conv_lat(input int i);
    case (i)
      0:       return CL_A;
      1:       return CL_B;
      default: return CL_C;
    endcase
  endfunction

  function automatic logic [31:0] seed_of(input int i);
    case (i)
      0:       return SEED_A;
      1:       return SEED_B;
      default: return SEED_C;
    endcase
  endfunction

  function automatic logic [31:0] next_val(input int i, input logic [31:0] g);
    if (i == 1) return (g >> 1) ^ (g[0] ? 32'h8020_0003 : 32'h0);
    return g + 32'd1;
  endfunction

  task automatic model_reset(input int i);
    m_ready[i] = 1'b0;
    m_out[i]   = 32'h0;
    m_cnt[i]   = 16'h0;
    m_gen[i]   = seed_of(i);
    m_run[i]   = 0;
  endtask

  // A sample appears once enable has been seen high on CONV_LAT+1 consecutive
  // edges since reset, abort or the previous accept (the accept edge counts).
  task automatic model_step(input int i, input logic r, input logic e);
    if (r) begin
      model_reset(i);
    end else if (m_ready[i]) begin
      if (e) begin
        m_cnt[i]   = m_cnt[i] + 16'h1;
        m_gen[i]   = next_val(i, m_gen[i]);
        m_ready[i] = 1'b0;
        m_run[i]   = 1;
      end
    end else if (!e) begin
      m_run[i] = 0;
    end else if (m_run[i] == conv_lat(i)) begin
      m_ready[i] = 1'b1;
      m_out[i]   = m_gen[i];
      m_run[i]   = 0;
    end else begin
      m_run[i] = m_run[i] + 1;
    end
  endtask

  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i, rst, en[i]);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("dut%0d_ready", i), {31'h0, rdy[i]}, {31'h0, m_ready[i]});
      check_val($sformatf("dut%0d_out", i), dout[i], m_out[i]);
      check_val($sformatf("dut%0d_cnt", i), {16'h0, cnt[i]}, {16'h0, m_cnt[i]});
    end
    if (rdy[1] && !prev_rdy[1] && exp_q_b.size() > 0) begin
      e = exp_q_b.pop_front();
      check_val("lfsr_seq", dout[1], e);
    end
    if (rdy[2] && !prev_rdy[2] && exp_q_c.size() > 0) begin
      e = exp_q_c.pop_front();
      check_val("wrap_seq", dout[2], e);
    end
    for (int i = 0; i < 3; i++) prev_rdy[i] = rdy[i];
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      model_reset(i);
      prev_rdy[i] = 1'b0;
    end
    exp_q_b.push_back(32'h0000_0001);
    exp_q_b.push_back(32'h8020_0003);
    exp_q_b.push_back(32'hC030_0002);
    exp_q_c.push_back(32'hFFFF_FFFF);
    exp_q_c.push_back(32'h0000_0000);

    // reset held with enable high: nothing may come out
    rst = 1'b1;
    en  = 3'b111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("rst_ready", {31'h0, rdy[0]}, 32'h0);
      check_val("rst_out", dout[0], 32'h0);
    end
    #1 rst = 1'b0;

    // directed stream / hold / abort on dut_a; dut_b and dut_c stream freely
    for (int t = 1; t <= 30; t++) begin
      en[0] = !((t >= 11 && t <= 13) || (t >= 21 && t <= 22));
      tick();
      if (t <= 4)               check_val("first_lat", {31'h0, rdy[0]}, 32'h0);
      if (t == 5)               check_val("s0", dout[0], 32'h100);
      if (t == 6)               check_val("acc0_cnt", {16'h0, cnt[0]}, 32'h1);
      if (t == 10 || t == 13)   check_val("s1_hold", dout[0], 32'h101);
      if (t >= 11 && t <= 13)   check_val("hold_ready", {31'h0, rdy[0]}, 32'h1);
      if (t == 14)              check_val("hold_acc", {16'h0, cnt[0]}, 32'h2);
      if (t == 18)              check_val("s2", dout[0], 32'h102);
      if (t >= 20 && t <= 26)   check_val("abort_noready", {31'h0, rdy[0]}, 32'h0);
      if (t == 27)              check_val("abort_same", dout[0], 32'h103);
    end
    check_val("lfsr_q_empty", exp_q_b.size(), 32'h0);
    check_val("wrap_q_empty", exp_q_c.size(), 32'h0);

    // random enable with occasional reset
    for (int k = 0; k < 3000; k++) begin
      en  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) en = en | 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    // mid-operation reset while dut_a is READY
    rst = 1'b1;
    en  = 3'b001;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 20 && !rdy[0]; k++) tick();
    check_val("pre_rst_ready", {31'h0, rdy[0]}, 32'h1);
    en[0] = 1'b1;
    tick();
    tick();
    for (int k = 0; k < 20 && !rdy[0]; k++) tick();
    check_val("pre_rst_val", dout[0], 32'h101);
    rst = 1'b1;
    tick();
    check_val("midrst_ready", {31'h0, rdy[0]}, 32'h0);
    check_val("midrst_out", dout[0], 32'h0);
    check_val("midrst_cnt", {16'h0, cnt[0]}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k < CL_A + 1; k++) tick();
    check_val("restart_seed", dout[0], SEED_A);
    check_val("restart_ready", {31'h0, rdy[0]}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
